// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, debug-loader and data-memory buses that meet at dmem_arbiter.
// Latency: none (wires only). Backpressure: requesters hold *_req_i until their ack pulse.
// slave = arbiter view, master = environment view (requesters plus memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic              cpu_ack_o;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_err_o;
    logic              cpu_stall_o;

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_ack_o, cpu_rdata_o, cpu_err_o, cpu_stall_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o, dbg_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_ack_o, cpu_rdata_o, cpu_err_o, cpu_stall_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o, dbg_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data memory between the CPU MEM stage and the debug loader.
// Latency: 3 cycles per access with a zero-wait memory (grant, busy, resp); memory wait cycles add 1:1.
// Backpressure: losers and in-flight requesters stall with req held; cpu_stall_o = cpu_req_i & ~cpu_ack_o.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              owner;       // 0 = cpu, 1 = dbg
    logic              last_grant;  // 0 = cpu, 1 = dbg
    logic [CNT_W-1:0]  cnt;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              cpu_ack;
    logic              dbg_ack;
    logic              cpu_err;
    logic              dbg_err;
    logic              grant_dbg;

    // dbg wins when it is alone, or on a tie when cpu was served last.
    assign grant_dbg = bus.dbg_req_i & (~bus.cpu_req_i | ~last_grant);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            dbg_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_i | bus.dbg_req_i) begin
                        owner     <= grant_dbg;
                        mem_req   <= 1'b1;
                        mem_we    <= grant_dbg ? bus.dbg_we_i    : bus.cpu_we_i;
                        mem_addr  <= grant_dbg ? bus.dbg_addr_i  : bus.cpu_addr_i;
                        mem_wdata <= grant_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack_i) begin
                        if (!mem_we) begin
                            if (owner) dbg_rdata <= bus.mem_rdata_i;
                            else       cpu_rdata <= bus.mem_rdata_i;
                        end
                        if (owner) begin
                            dbg_ack <= 1'b1;
                            dbg_err <= 1'b0;
                        end else begin
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b0;
                        end
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Memory never answered: complete with an error and zeroed data.
                        if (owner) begin
                            dbg_rdata <= '0;
                            dbg_ack   <= 1'b1;
                            dbg_err   <= 1'b1;
                        end else begin
                            cpu_rdata <= '0;
                            cpu_ack   <= 1'b1;
                            cpu_err   <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    cpu_ack    <= 1'b0;
                    dbg_ack    <= 1'b0;
                    cpu_err    <= 1'b0;
                    dbg_err    <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

    assign bus.cpu_ack_o   = cpu_ack;
    assign bus.cpu_rdata_o = cpu_rdata;
    assign bus.cpu_err_o   = cpu_err;
    assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_ack;

    assign bus.dbg_ack_o   = dbg_ack;
    assign bus.dbg_rdata_o = dbg_rdata;
    assign bus.dbg_err_o   = dbg_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: ref_mem is the model's view, bk_mem is what the memory responder serves.
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] bk_mem  [16];

    // Requester state per port (0 = cpu, 1 = dbg).
    bit            r_req   [2];
    bit            r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];
    bit            seen_ack[2];

    // Transaction-level model.
    int            it      = 0;
    int            free_it = 1 << 30;
    bit            act     = 1'b0;
    int            own     = 0;
    int            last    = 1;
    int            g_it    = 0;
    int            end_it  = 0;
    int            lat     = 0;
    bit            e_err   = 1'b0;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [DW-1:0] e_rd [2];

    int lat_mode  = 0;
    bit force_ack = 1'b0;
    bit spur_en   = 1'b0;

    function automatic int pick_lat();
        if (lat_mode >= 0) return lat_mode;
        if ($urandom_range(0, 15) == 0) return NEVER;
        return $urandom_range(0, 5);
    endfunction

    task automatic apply();
        bus.cpu_req_i   = r_req[0];
        bus.cpu_we_i    = r_we[0];
        bus.cpu_addr_i  = r_addr[0];
        bus.cpu_wdata_i = r_wdata[0];
        bus.dbg_req_i   = r_req[1];
        bus.dbg_we_i    = r_we[1];
        bus.dbg_addr_i  = r_addr[1];
        bus.dbg_wdata_i = r_wdata[1];
    endtask

    task automatic set_port(input int p, input bit req, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        r_req[p]   = req;
        r_we[p]    = we;
        r_addr[p]  = addr;
        r_wdata[p] = wdata;
        apply();
    endtask

    // One clock: sample after the edge, compare against the model, then let the memory respond.
    task automatic cycle();
        bit         ea0, ea1, emreq;
        logic [3:0] idx;
        @(posedge clk);
        #1;
        it++;
        if (rst) begin
            act     = 1'b0;
            last    = 1;
            free_it = it;
            e_rd[0] = '0;
            e_rd[1] = '0;
            chk("rst_mem_req", bus.mem_req_o, 0);
            chk("rst_mem_we", bus.mem_we_o, 0);
            chk("rst_mem_addr", bus.mem_addr_o, 0);
            chk("rst_mem_wdata", bus.mem_wdata_o, 0);
            chk("rst_acks", {bus.cpu_ack_o, bus.dbg_ack_o}, 0);
            chk("rst_errs", {bus.cpu_err_o, bus.dbg_err_o}, 0);
            chk("rst_cpu_rdata", bus.cpu_rdata_o, 0);
            chk("rst_dbg_rdata", bus.dbg_rdata_o, 0);
            seen_ack[0] = 1'b0;
            seen_ack[1] = 1'b0;
        end else begin
            if (!act && (it - 1 >= free_it) && (bus.cpu_req_i || bus.dbg_req_i)) begin
                own     = (bus.cpu_req_i && bus.dbg_req_i) ? 1 - last : (bus.dbg_req_i ? 1 : 0);
                o_we    = own ? bus.dbg_we_i    : bus.cpu_we_i;
                o_addr  = own ? bus.dbg_addr_i  : bus.cpu_addr_i;
                o_wdata = own ? bus.dbg_wdata_i : bus.cpu_wdata_i;
                act     = 1'b1;
                g_it    = it;
                lat     = pick_lat();
                e_err   = (lat >= TO);
                end_it  = it + (e_err ? TO - 1 : lat);
            end
            emreq = act && (it <= end_it);
            ea0   = act && (it == end_it + 1) && (own == 0);
            ea1   = act && (it == end_it + 1) && (own == 1);
            chk("mem_req", bus.mem_req_o, emreq);
            if (emreq) begin
                chk("mem_we", bus.mem_we_o, o_we);
                chk("mem_addr", bus.mem_addr_o, o_addr);
                chk("mem_wdata", bus.mem_wdata_o, o_wdata);
            end
            if (ea0 || ea1) begin
                idx = o_addr[5:2];
                if (e_err)      e_rd[own]    = '0;
                else if (!o_we) e_rd[own]    = ref_mem[idx];
                else            ref_mem[idx] = o_wdata;
                chk("err", own ? bus.dbg_err_o : bus.cpu_err_o, e_err);
                last    = own;
                act     = 1'b0;
                free_it = it + 1;
            end
            chk("cpu_ack", bus.cpu_ack_o, ea0);
            chk("dbg_ack", bus.dbg_ack_o, ea1);
            chk("cpu_rdata", bus.cpu_rdata_o, e_rd[0]);
            chk("dbg_rdata", bus.dbg_rdata_o, e_rd[1]);
            chk("cpu_stall", bus.cpu_stall_o, bus.cpu_req_i && !ea0);
            seen_ack[0] = bus.cpu_ack_o;
            seen_ack[1] = bus.dbg_ack_o;
        end
        bus.mem_rdata_i = $urandom;
        bus.mem_ack_i   = 1'b0;
        if (force_ack) begin
            bus.mem_ack_i = 1'b1;
            force_ack     = 1'b0;
        end else if (bus.mem_req_o) begin
            if (act && !e_err && (it == g_it + lat)) begin
                bus.mem_ack_i = 1'b1;
                idx = bus.mem_addr_o[5:2];
                if (bus.mem_we_o) bk_mem[idx] = bus.mem_wdata_o;
                else              bus.mem_rdata_i = bk_mem[idx];
            end
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            bus.mem_ack_i = 1'b1;
        end
    endtask

    task automatic new_txn(input int p);
        r_we[p]    = 1'($urandom_range(0, 1));
        r_addr[p]  = $urandom;
        r_wdata[p] = $urandom;
    endtask

    task automatic drive_port(input int p);
        if (r_req[p] && seen_ack[p]) begin
            r_req[p] = 1'($urandom_range(0, 1));
            if (r_req[p]) new_txn(p);
        end else if (!r_req[p] && $urandom_range(0, 2) == 0) begin
            r_req[p] = 1'b1;
            new_txn(p);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  got;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bk_mem[i]  = ref_mem[i];
        end
        ref_mem[0] = 32'd5;
        bk_mem[0]  = 32'd5;
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, '0, '0);
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;

        // Single zero-wait CPU read of address 0 holding 5.
        lat_mode = 0;
        set_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_stall_c0", bus.cpu_stall_o, 1);
        cycle();
        chk("t1_mreq_c1", bus.mem_req_o, 1);
        chk("t1_stall_c1", bus.cpu_stall_o, 1);
        cycle();
        chk("t1_ack_c2", bus.cpu_ack_o, 1);
        chk("t1_rdata_c2", bus.cpu_rdata_o, 32'd5);
        chk("t1_err_c2", bus.cpu_err_o, 0);
        chk("t1_stall_c2", bus.cpu_stall_o, 0);
        set_port(0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("t1_ack_c3", bus.cpu_ack_o, 0);

        // CPU write with three memory wait cycles.
        lat_mode = 3;
        set_port(0, 1'b1, 1'b1, 32'h0c, 32'h1234);
        for (int c = 1; c <= 4; c++) begin
            cycle();
            chk("t2_mreq", bus.mem_req_o, 1);
            chk("t2_we", bus.mem_we_o, 1);
            chk("t2_addr", bus.mem_addr_o, 32'h0c);
            chk("t2_wdata", bus.mem_wdata_o, 32'h1234);
        end
        cycle();
        chk("t2_ack_c5", bus.cpu_ack_o, 1);
        chk("t2_rdata_kept", bus.cpu_rdata_o, 32'd5);
        set_port(0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Simultaneous held reads from reset: strict alternation starting with cpu.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        lat_mode = 0;
        set_port(0, 1'b1, 1'b0, 32'h10, '0);
        set_port(1, 1'b1, 1'b0, 32'h20, '0);
        for (int c = 1; c <= 12; c++) begin
            cycle();
            chk("t3_cpu_ack", bus.cpu_ack_o, (c % 6) == 2);
            chk("t3_dbg_ack", bus.dbg_ack_o, (c % 6) == 5);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        cycle();

        // Memory never acks: error completion after TIMEOUT busy cycles, then a late ack is ignored.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        lat_mode = NEVER;
        set_port(0, 1'b1, 1'b0, 32'h04, '0);
        n   = 0;
        got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (bus.mem_req_o) n++;
            if (bus.cpu_ack_o) begin
                got = 1'b1;
                chk("t4_err", bus.cpu_err_o, 1);
                chk("t4_rdata", bus.cpu_rdata_o, 0);
                break;
            end
        end
        chk("t4_got_ack", got, 1);
        chk("t4_req_cycles", n, TO);
        set_port(0, 1'b0, 1'b0, '0, '0);
        force_ack = 1'b1;
        repeat (3) begin
            cycle();
            chk("t4_late_ack", {bus.cpu_ack_o, bus.dbg_ack_o}, 0);
        end

        // Reset during a dbg write in BUSY aborts it; the next tie goes to cpu.
        lat_mode = NEVER;
        set_port(1, 1'b1, 1'b1, 32'h08, 32'hdead);
        cycle();
        cycle();
        chk("t5_busy", bus.mem_req_o, 1);
        rst = 1'b1;
        cycle();
        chk("t5_abort_req", bus.mem_req_o, 0);
        chk("t5_abort_ack", bus.dbg_ack_o, 0);
        rst = 1'b0;
        lat_mode = 0;
        set_port(0, 1'b1, 1'b0, 32'h00, '0);
        cycle();
        chk("t5_tie_addr", bus.mem_addr_o, 32'h00);
        chk("t5_tie_we", bus.mem_we_o, 0);
        cycle();
        chk("t5_cpu_ack", bus.cpu_ack_o, 1);
        chk("t5_no_dbg_ack", bus.dbg_ack_o, 0);
        set_port(0, 1'b0, 1'b0, '0, '0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            cycle();
            got = bus.dbg_ack_o;
        end
        chk("t5_dbg_done", got, 1);
        set_port(1, 1'b0, 1'b0, '0, '0);
        cycle();

        // dbg arrives while cpu is in BUSY: waits, memory fields stay on the cpu access.
        lat_mode = 4;
        set_port(0, 1'b1, 1'b0, 32'h14, '0);
        cycle();
        set_port(1, 1'b1, 1'b1, 32'h18, 32'hbeef);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus.mem_req_o) begin
                chk("t6_hold_addr", bus.mem_addr_o, 32'h14);
                chk("t6_hold_we", bus.mem_we_o, 0);
            end
            cycle();
            got = bus.cpu_ack_o;
        end
        chk("t6_cpu_ack", got, 1);
        set_port(0, 1'b0, 1'b0, '0, '0);
        cycle();
        cycle();
        chk("t6_dbg_addr", bus.mem_addr_o, 32'h18);
        chk("t6_dbg_we", bus.mem_we_o, 1);
        chk("t6_dbg_wdata", bus.mem_wdata_o, 32'hbeef);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            cycle();
            got = bus.dbg_ack_o;
        end
        chk("t6_dbg_ack", got, 1);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Random traffic, latencies, timeouts, stray acks and occasional resets.
        lat_mode = -1;
        spur_en  = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cycle();
            drive_port(0);
            drive_port(1);
            apply();
            rst = (!bus.mem_ack_i && $urandom_range(0, 199) == 0);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
